// File: rtl/stream_distributor_if.sv
// stream_distributor_if: one serial input stream and KERNEL_SIZE parallel output lanes.
interface stream_distributor_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 18
);
  logic                             s_axis_tvalid;
  logic [DATA_WIDTH-1:0]            s_axis_tdata;
  logic                             s_axis_tlast;
  logic                             s_axis_tready;
  logic [KERNEL_SIZE-1:0]           m_axis_tvalid;
  logic [DATA_WIDTH*KERNEL_SIZE-1:0] m_axis_tdata;
  logic [KERNEL_SIZE-1:0]           m_axis_tlast;
  logic [KERNEL_SIZE-1:0]           m_axis_tready;
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/stream_distributor.sv
// stream_distributor: deals input words round-robin onto per-lane FIFOs; tlast restarts at lane 0.
module stream_distributor #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 18,
  parameter int LANE_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  stream_distributor_if.slave            bus,
  output logic [$clog2(KERNEL_SIZE)-1:0] lane_sel,
  output logic                           busy
);
  localparam int LW = $clog2(KERNEL_SIZE);
  localparam int AW = $clog2(LANE_DEPTH);
  localparam int CW = AW + 1;
  logic [KERNEL_SIZE-1:0]            full, valid_v, last_v;
  logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_v;
  logic                              accept;
  // Ready depends only on registered occupancy, never on downstream ready.
  assign bus.s_axis_tready = ~full[lane_sel];
  assign accept            = bus.s_axis_tvalid & bus.s_axis_tready;
  assign bus.m_axis_tvalid = valid_v;
  assign bus.m_axis_tlast  = last_v;
  assign bus.m_axis_tdata  = data_v;
  assign busy              = |valid_v;
  always_ff @(posedge clk or posedge rst)
    if (rst) lane_sel <= '0;
    else if (accept) lane_sel <= (bus.s_axis_tlast || lane_sel == LW'(KERNEL_SIZE-1)) ? '0 : lane_sel + 1'b1;
  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH:0] mem [LANE_DEPTH];
    logic [AW-1:0]       wp, rp;
    logic [CW-1:0]       cnt;
    logic                push, pop;
    assign push = accept && lane_sel == LW'(i);
    assign pop  = valid_v[i] && bus.m_axis_tready[i];
    always_ff @(posedge clk)
      if (push) mem[wp] <= {bus.s_axis_tlast, bus.s_axis_tdata};
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    assign full[i]    = cnt == CW'(LANE_DEPTH);
    assign valid_v[i] = cnt != '0;
    // Gating with valid keeps the outputs at zero while a lane is empty, including after reset.
    assign last_v[i]  = valid_v[i] && mem[rp][DATA_WIDTH];
    assign data_v[i*DATA_WIDTH +: DATA_WIDTH] = valid_v[i] ? mem[rp][DATA_WIDTH-1:0] : '0;
  end
endmodule

// File: tb/tb_stream_distributor.sv
// tb_stream_distributor: directed plan scenarios plus random traffic, checked against a queue model.
module tb_stream_distributor;
  localparam int KS = 3;
  localparam int DW = 18;
  localparam int LD = 2;
  localparam int LW = $clog2(KS);
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] lane_sel;
  logic          busy;
  int            checks = 0;
  int            failures = 0;
  logic [DW:0]   q [KS][$];
  int            ptr = 0;
  stream_distributor_if #(.KERNEL_SIZE(KS), .DATA_WIDTH(DW)) bus ();
  stream_distributor #(.KERNEL_SIZE(KS), .DATA_WIDTH(DW), .LANE_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .lane_sel(lane_sel), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: one queue per lane plus a dealing pointer; compared every cycle, then advanced to the next edge.
  always @(negedge clk) begin
    logic acc;
    logic any;
    if (rst) begin
      for (int i = 0; i < KS; i++) q[i].delete();
      ptr = 0;
    end
    any = 1'b0;
    for (int i = 0; i < KS; i++) any |= q[i].size() != 0;
    chk("m_ready", bus.s_axis_tready, q[ptr].size() < LD);
    chk("m_sel", lane_sel, ptr);
    chk("m_busy", busy, any);
    for (int i = 0; i < KS; i++) begin
      chk($sformatf("m_valid%0d", i), bus.m_axis_tvalid[i], q[i].size() != 0);
      if (q[i].size() != 0) begin
        chk($sformatf("m_data%0d", i), bus.m_axis_tdata[i*DW +: DW], q[i][0][DW-1:0]);
        chk($sformatf("m_last%0d", i), bus.m_axis_tlast[i], q[i][0][DW]);
      end
    end
    if (!rst) begin
      acc = bus.s_axis_tvalid && q[ptr].size() < LD;
      for (int i = 0; i < KS; i++)
        if (q[i].size() != 0 && bus.m_axis_tready[i]) void'(q[i].pop_front());
      if (acc) begin
        q[ptr].push_back({bus.s_axis_tlast, bus.s_axis_tdata});
        ptr = (bus.s_axis_tlast || ptr == KS-1) ? 0 : ptr + 1;
      end
    end
  end
  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic send(input logic [DW-1:0] d, input logic l);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.s_axis_tready) begin
        @(posedge clk); #1;
        bus.s_axis_tvalid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1'b0, 1'b1);
    bus.s_axis_tvalid = 1'b0;
  endtask
  initial begin
    logic took;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = '1;
    @(posedge clk); #1;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = DW'(i + 1);
      @(negedge clk);
      chk("t1_sel", lane_sel, i % KS);
      chk("t1_ready", bus.s_axis_tready, 1'b1);
      @(posedge clk); #1;
      chk("t1_valid", bus.m_axis_tvalid[i % KS], 1'b1);
      chk("t1_data", bus.m_axis_tdata[(i % KS)*DW +: DW], DW'(i + 1));
    end
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("t1_sel_end", lane_sel, 1);
    @(posedge clk); #1;
    reset_dut();
    bus.m_axis_tready = 3'b101;
    for (int n = 0; n < 7; n++) send(DW'('h100 + n), 1'b0);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = DW'('h107);
    @(negedge clk);
    chk("t2_stall_ready", bus.s_axis_tready, 1'b0);
    chk("t2_stall_sel", lane_sel, 1);
    chk("t2_head1", bus.m_axis_tdata[DW +: DW], DW'('h101));
    @(posedge clk); #1;
    bus.m_axis_tready = '1;
    @(negedge clk);
    chk("t2_still_stalled", bus.s_axis_tready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_head4", bus.m_axis_tdata[DW +: DW], DW'('h104));
    chk("t2_resume", bus.s_axis_tready, 1'b1);
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("t2_sel_after", lane_sel, 2);
    @(posedge clk); #1;
    reset_dut();
    send(DW'('h10), 1'b0);
    chk("t3_l0", bus.m_axis_tdata[0 +: DW], DW'('h10));
    send(DW'('h11), 1'b1);
    chk("t3_l1", bus.m_axis_tdata[DW +: DW], DW'('h11));
    chk("t3_last1", bus.m_axis_tlast[1], 1'b1);
    chk("t3_sel0", lane_sel, 0);
    send(DW'('h20), 1'b0);
    chk("t3_l0b", bus.m_axis_tdata[0 +: DW], DW'('h20));
    chk("t3_l2_empty", bus.m_axis_tvalid[2], 1'b0);
    reset_dut();
    bus.m_axis_tready = 3'b110;
    send(DW'('hA), 1'b0);
    send(DW'('hB), 1'b0);
    send(DW'('hC), 1'b0);
    send(DW'('hD), 1'b0);
    send(DW'('hE), 1'b1);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = DW'('hF);
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = '1;
    @(negedge clk);
    chk("t4_blocked", bus.s_axis_tready, 1'b0);
    chk("t4_sel", lane_sel, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_ready", bus.s_axis_tready, 1'b1);
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("t4_sel_after", lane_sel, 1);
    chk("t4_head", bus.m_axis_tdata[0 +: DW], DW'('hF));
    @(posedge clk); #1;
    reset_dut();
    bus.m_axis_tready = '0;
    send(DW'('h31), 1'b0);
    send(DW'('h32), 1'b0);
    send(DW'('h33), 1'b0);
    @(negedge clk);
    chk("t5_busy_before", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_valid", bus.m_axis_tvalid, 3'b000);
    chk("t5_busy", busy, 1'b0);
    chk("t5_sel", lane_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.m_axis_tready = '1;
    send(DW'('h55), 1'b0);
    chk("t5_first_lane0", bus.m_axis_tdata[0 +: DW], DW'('h55));
    reset_dut();
    bus.m_axis_tready = 3'b011;
    send(DW'('h1), 1'b0);
    send(DW'('h2), 1'b0);
    send(DW'('h2ABCD), 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t6_hold_data", bus.m_axis_tdata[2*DW +: DW], DW'('h2ABCD));
      chk("t6_hold_valid", bus.m_axis_tvalid[2], 1'b1);
    end
    @(posedge clk); #1;
    bus.m_axis_tready = '1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      took = bus.s_axis_tvalid && bus.s_axis_tready;
      @(posedge clk); #1;
      if (!bus.s_axis_tvalid || took) begin
        bus.s_axis_tvalid = $urandom_range(0, 3) != 0;
        bus.s_axis_tdata  = DW'($urandom);
        bus.s_axis_tlast  = $urandom_range(0, 4) == 0;
      end
      for (int i = 0; i < KS; i++) bus.m_axis_tready[i] = $urandom_range(0, 9) < 7;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = '1;
    repeat (LD + 2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_busy", busy, 1'b0);
    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
